warp_context_table: RTL and testbench
=====================================

WARP_CONTEXT_TABLE -- requirements
Module: warp_context_table

Interface
REQ-001 NUM_WARPS, default WARPS_PER_CORE, number of warp slots.
REQ-002 PC_INCR, default 4, PC advance per issued instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 launch_valid  input  1  request to start a warp.
REQ-006 launch_warp_id  input  WARP_ID_WIDTH  target slot.
REQ-007 launch_pc  input  DATA_WIDTH  start PC.
REQ-008 launch_mask  input  WARP_SIZE  initial active-thread mask.
REQ-009 launch_ready  output  1  target slot free (ctx_valid=0 or status WARP_DONE); combinational.
REQ-010 issue_ack  input  1  scheduler-selected warp issued this cycle.
REQ-011 issue_warp_id  input  WARP_ID_WIDTH  issued warp (scheduler selected_warp_id).
REQ-012 pc_wr_valid  input  1  branch/divergence PC+mask overwrite.
REQ-013 pc_wr_warp_id  input  WARP_ID_WIDTH  overwrite target.
REQ-014 pc_wr_pc  input  DATA_WIDTH  new PC.
REQ-015 pc_wr_mask  input  WARP_SIZE  new mask.
REQ-016 evt_valid  input  1  status event strobe.
REQ-017 evt_warp_id  input  WARP_ID_WIDTH  event target.
REQ-018 evt_op  input  2  0=WAIT, 1=WAKE, 2=BARRIER, 3=EXIT.
REQ-019 ctx_pc  output  NUM_WARPS x DATA_WIDTH  packed per-warp PC, registered.
REQ-020 ctx_mask  output  NUM_WARPS x WARP_SIZE  packed per-warp mask, registered.
REQ-021 ctx_status  output  NUM_WARPS x 3  packed pkg_opengpu warp status, registered.
REQ-022 ctx_age  output  NUM_WARPS x 8  packed per-warp age, registered.
REQ-023 ctx_valid  output  NUM_WARPS  slot occupied, registered.
REQ-024 bar_release  output  1  one-cycle pulse when a barrier releases.

Function
REQ-025 Accepted launch (launch_valid & launch_ready): next cycle valid=1, pc=launch_pc, mask=launch_mask, status=WARP_READY, age=0; launch with launch_ready=0 ignored, slot unchanged.
REQ-026 issue_ack on a READY valid warp: pc += PC_INCR (modulo 2^DATA_WIDTH), age=0; issue_ack on non-READY or invalid warp ignored.
REQ-027 pc_wr_valid on valid warp: pc=pc_wr_pc, mask=pc_wr_mask; overrides issue increment for same warp same cycle.
REQ-028 WAIT: READY->WAITING; WAKE: WAITING->READY; other source states unchanged.
REQ-029 BARRIER: READY->BLOCKED.
REQ-030 Barrier release: when every valid non-DONE warp is BLOCKED (at least one), next cycle all BLOCKED warps -> READY and bar_release=1 for that one cycle.
REQ-031 EXIT: any valid state -> WARP_DONE; DONE warps exempt from barrier count and aging; ctx_valid stays 1 until relaunched.
REQ-032 Same-warp same-cycle priority: launch > EXIT > barrier release > other evt_op > issue status effects; pc_wr and issue PC update per REQ-027.
REQ-033 Distinct warps updated by different sources in one cycle all take effect.
REQ-034 Out-of-range warp ids (>= NUM_WARPS) ignored on every port.

Reset
REQ-035 rst=1 at a rising edge: ctx_valid=0, ctx_pc=0, ctx_mask=0, ctx_status=WARP_DONE, ctx_age=0, bar_release=0, all inputs ignored that edge.
REQ-036 Reset mid-operation (pending barrier, waiting warps) discards all state; no bar_release pulse after reset.

Configuration
REQ-037 WARP_CTX_AGE_EN defined: each valid, non-DONE, non-issued warp's age increments by 1 per cycle, saturating at 255; issued/launched warp ages set to 0.
REQ-038 WARP_CTX_AGE_EN undefined: ctx_age constant 0, no age registers.

Verification
REQ-039 Reset, launch w0 pc=0x100 mask=0xFFFFFFFF -> next cycle ctx_valid[0]=1, status READY, pc 0x100, launch_ready for w0 = 0.
REQ-040 issue_ack w0 three cycles -> pc 0x10C; same cycle pc_wr w0 pc=0x400 with issue -> pc 0x400.
REQ-041 Launch w0..w3, BARRIER w0,w1,w2 -> no release; BARRIER w3 -> all READY next cycle, bar_release single pulse.
REQ-042 EXIT w3, BARRIER w0..w2 -> release occurs without w3; w3 status DONE, launch_ready for w3 = 1.
REQ-043 AGE_EN: w1 idle 300 cycles -> age saturates 255; issue w1 -> age 0; AGE_EN off -> ctx_age all 0.
REQ-044 WAIT w2 then WAKE w2 -> WAITING then READY; WAKE on READY w1 -> unchanged; rst mid-barrier -> all slots cleared.

Source files
------------

// File: rtl/warp_context_table.sv
// rtl/warp_context_table.sv - per-warp PC/mask/status/age context table with barrier release
// Optional per-warp aging is built when WARP_CTX_AGE_EN is defined.
module warp_context_table #(
  parameter int WARPS_PER_CORE = 8,
  parameter int NUM_WARPS      = WARPS_PER_CORE,
  parameter int DATA_WIDTH     = 32,
  parameter int WARP_SIZE      = 32,
  parameter int PC_INCR        = 4,
  parameter int WARP_ID_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            launch_valid,
  input  logic [WARP_ID_WIDTH-1:0]        launch_warp_id,
  input  logic [DATA_WIDTH-1:0]           launch_pc,
  input  logic [WARP_SIZE-1:0]            launch_mask,
  output logic                            launch_ready,
  input  logic                            issue_ack,
  input  logic [WARP_ID_WIDTH-1:0]        issue_warp_id,
  input  logic                            pc_wr_valid,
  input  logic [WARP_ID_WIDTH-1:0]        pc_wr_warp_id,
  input  logic [DATA_WIDTH-1:0]           pc_wr_pc,
  input  logic [WARP_SIZE-1:0]            pc_wr_mask,
  input  logic                            evt_valid,
  input  logic [WARP_ID_WIDTH-1:0]        evt_warp_id,
  input  logic [1:0]                      evt_op,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] ctx_pc,
  output logic [NUM_WARPS*WARP_SIZE-1:0]  ctx_mask,
  output logic [NUM_WARPS*3-1:0]          ctx_status,
  output logic [NUM_WARPS*8-1:0]          ctx_age,
  output logic [NUM_WARPS-1:0]            ctx_valid,
  output logic                            bar_release
);

  localparam logic [2:0] WARP_READY   = 3'd1;
  localparam logic [2:0] WARP_WAITING = 3'd2;
  localparam logic [2:0] WARP_BLOCKED = 3'd3;
  localparam logic [2:0] WARP_DONE    = 3'd4;

  localparam logic [1:0] EVT_WAIT    = 2'd0;
  localparam logic [1:0] EVT_WAKE    = 2'd1;
  localparam logic [1:0] EVT_BARRIER = 2'd2;
  localparam logic [1:0] EVT_EXIT    = 2'd3;

  logic [DATA_WIDTH-1:0] pc_q     [NUM_WARPS];
  logic [WARP_SIZE-1:0]  mask_q   [NUM_WARPS];
  logic [2:0]            status_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]  valid_q;

  logic [NUM_WARPS-1:0]  launch_hit;
  logic [NUM_WARPS-1:0]  issue_hit;
  logic [NUM_WARPS-1:0]  pcwr_hit;
  logic [NUM_WARPS-1:0]  evt_hit;
  logic                  release_now;
  logic                  any_blocked;
  logic                  any_unblocked;

  // Ids that match no slot never raise a hit, which filters out-of-range ids.
  always_comb begin
    launch_ready  = 1'b0;
    launch_hit    = '0;
    issue_hit     = '0;
    pcwr_hit      = '0;
    evt_hit       = '0;
    any_blocked   = 1'b0;
    any_unblocked = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (launch_warp_id == WARP_ID_WIDTH'(w))
        launch_ready = !valid_q[w] || (status_q[w] == WARP_DONE);
      if (valid_q[w] && status_q[w] == WARP_BLOCKED)
        any_blocked = 1'b1;
      if (valid_q[w] && status_q[w] != WARP_BLOCKED && status_q[w] != WARP_DONE)
        any_unblocked = 1'b1;
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      launch_hit[w] = launch_valid && launch_ready && (launch_warp_id == WARP_ID_WIDTH'(w));
      issue_hit[w]  = issue_ack && (issue_warp_id == WARP_ID_WIDTH'(w)) &&
                      valid_q[w] && (status_q[w] == WARP_READY);
      pcwr_hit[w]   = pc_wr_valid && (pc_wr_warp_id == WARP_ID_WIDTH'(w)) && valid_q[w];
      evt_hit[w]    = evt_valid && (evt_warp_id == WARP_ID_WIDTH'(w)) && valid_q[w];
    end
    release_now = any_blocked && !any_unblocked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      bar_release <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]     <= '0;
        mask_q[w]   <= '0;
        status_q[w] <= WARP_DONE;
      end
    end else begin
      bar_release <= release_now;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (launch_hit[w]) begin
          valid_q[w] <= 1'b1;
          pc_q[w]    <= launch_pc;
          mask_q[w]  <= launch_mask;
        end else if (pcwr_hit[w]) begin
          pc_q[w]    <= pc_wr_pc;
          mask_q[w]  <= pc_wr_mask;
        end else if (issue_hit[w]) begin
          pc_q[w]    <= pc_q[w] + DATA_WIDTH'(PC_INCR);
        end

        if (launch_hit[w]) begin
          status_q[w] <= WARP_READY;
        end else if (evt_hit[w] && evt_op == EVT_EXIT) begin
          status_q[w] <= WARP_DONE;
        end else if (release_now && valid_q[w] && status_q[w] == WARP_BLOCKED) begin
          status_q[w] <= WARP_READY;
        end else if (evt_hit[w]) begin
          case (evt_op)
            EVT_WAIT:    if (status_q[w] == WARP_READY)   status_q[w] <= WARP_WAITING;
            EVT_WAKE:    if (status_q[w] == WARP_WAITING) status_q[w] <= WARP_READY;
            EVT_BARRIER: if (status_q[w] == WARP_READY)   status_q[w] <= WARP_BLOCKED;
            default:     status_q[w] <= status_q[w];
          endcase
        end
      end
    end
  end

`ifdef WARP_CTX_AGE_EN
  logic [7:0] age_q [NUM_WARPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) age_q[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (launch_hit[w] || issue_hit[w])
          age_q[w] <= '0;
        else if (valid_q[w] && status_q[w] != WARP_DONE && age_q[w] != 8'hFF)
          age_q[w] <= age_q[w] + 8'd1;
      end
    end
  end

  always_comb begin
    ctx_age = '0;
    for (int w = 0; w < NUM_WARPS; w++) ctx_age[w*8 +: 8] = age_q[w];
  end
`else
  assign ctx_age = '0;
`endif

  always_comb begin
    ctx_pc     = '0;
    ctx_mask   = '0;
    ctx_status = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      ctx_pc[w*DATA_WIDTH +: DATA_WIDTH] = pc_q[w];
      ctx_mask[w*WARP_SIZE +: WARP_SIZE] = mask_q[w];
      ctx_status[w*3 +: 3]               = status_q[w];
    end
  end

  assign ctx_valid = valid_q;

endmodule

// File: tb/tb_warp_context_table.sv
// tb/tb_warp_context_table.sv - directed self-checking bench for warp_context_table
module tb_warp_context_table;

  localparam int NW = 6;
  localparam int DW = 32;
  localparam int WS = 32;
  localparam int IW = 3;

  localparam logic [2:0] S_READY   = 3'd1;
  localparam logic [2:0] S_WAITING = 3'd2;
  localparam logic [2:0] S_BLOCKED = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic clk = 1'b0;
  logic rst;
  logic launch_valid;
  logic [IW-1:0] launch_warp_id;
  logic [DW-1:0] launch_pc;
  logic [WS-1:0] launch_mask;
  logic launch_ready;
  logic issue_ack;
  logic [IW-1:0] issue_warp_id;
  logic pc_wr_valid;
  logic [IW-1:0] pc_wr_warp_id;
  logic [DW-1:0] pc_wr_pc;
  logic [WS-1:0] pc_wr_mask;
  logic evt_valid;
  logic [IW-1:0] evt_warp_id;
  logic [1:0] evt_op;
  logic [NW*DW-1:0] ctx_pc;
  logic [NW*WS-1:0] ctx_mask;
  logic [NW*3-1:0] ctx_status;
  logic [NW*8-1:0] ctx_age;
  logic [NW-1:0] ctx_valid;
  logic bar_release;

  int checks = 0;
  int errors = 0;

  warp_context_table #(.NUM_WARPS(NW), .DATA_WIDTH(DW), .WARP_SIZE(WS), .PC_INCR(4)) dut (
    .clk(clk), .rst(rst),
    .launch_valid(launch_valid), .launch_warp_id(launch_warp_id), .launch_pc(launch_pc),
    .launch_mask(launch_mask), .launch_ready(launch_ready),
    .issue_ack(issue_ack), .issue_warp_id(issue_warp_id),
    .pc_wr_valid(pc_wr_valid), .pc_wr_warp_id(pc_wr_warp_id), .pc_wr_pc(pc_wr_pc),
    .pc_wr_mask(pc_wr_mask),
    .evt_valid(evt_valid), .evt_warp_id(evt_warp_id), .evt_op(evt_op),
    .ctx_pc(ctx_pc), .ctx_mask(ctx_mask), .ctx_status(ctx_status), .ctx_age(ctx_age),
    .ctx_valid(ctx_valid), .bar_release(bar_release)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] st(input int w);
    return ctx_status[w*3 +: 3];
  endfunction

  function automatic logic [DW-1:0] pcv(input int w);
    return ctx_pc[w*DW +: DW];
  endfunction

  function automatic logic [7:0] agev(input int w);
    return ctx_age[w*8 +: 8];
  endfunction

  task automatic idle_inputs();
    launch_valid = 0; issue_ack = 0; pc_wr_valid = 0; evt_valid = 0;
  endtask

  task automatic launch(input int w, input logic [DW-1:0] pc, input logic [WS-1:0] m);
    launch_valid = 1; launch_warp_id = IW'(w); launch_pc = pc; launch_mask = m;
    tick();
    launch_valid = 0;
  endtask

  task automatic evt(input int w, input logic [1:0] op);
    evt_valid = 1; evt_warp_id = IW'(w); evt_op = op;
    tick();
    evt_valid = 0;
  endtask

  initial begin
    rst = 1; idle_inputs();
    launch_warp_id = 0; launch_pc = 0; launch_mask = 0; issue_warp_id = 0;
    pc_wr_warp_id = 0; pc_wr_pc = 0; pc_wr_mask = 0; evt_warp_id = 0; evt_op = 0;
    tick(); tick();
    rst = 0;
    chk("rst_valid", 64'(ctx_valid), 64'h0);
    chk("rst_status", 64'(ctx_status), 64'({NW{S_DONE}}));
    chk("rst_pc0", 64'(pcv(0)), 64'h0);
    chk("rst_mask", 64'(ctx_mask[63:0]), 64'h0);
    chk("rst_age", 64'(ctx_age), 64'h0);
    chk("rst_bar", 64'(bar_release), 64'h0);

    launch_warp_id = 0;
    #1 chk("ready_w0_free", 64'(launch_ready), 64'h1);
    launch(0, 32'h100, 32'hFFFF_FFFF);
    chk("launch_valid0", 64'(ctx_valid[0]), 64'h1);
    chk("launch_st0", 64'(st(0)), 64'(S_READY));
    chk("launch_pc0", 64'(pcv(0)), 64'h100);
    chk("launch_mask0", 64'(ctx_mask[31:0]), 64'hFFFF_FFFF);
    chk("ready_w0_busy", 64'(launch_ready), 64'h0);

    launch(0, 32'h999, 32'h1);
    chk("relaunch_ignored_pc", 64'(pcv(0)), 64'h100);

    issue_ack = 1; issue_warp_id = 0;
    tick(); tick(); tick();
    issue_ack = 0;
    chk("issue3_pc", 64'(pcv(0)), 64'h10C);
    issue_ack = 1; pc_wr_valid = 1; pc_wr_warp_id = 0; pc_wr_pc = 32'h400; pc_wr_mask = 32'hF;
    tick();
    idle_inputs();
    chk("pcwr_over_issue", 64'(pcv(0)), 64'h400);
    chk("pcwr_mask", 64'(ctx_mask[31:0]), 64'hF);

    launch_warp_id = 3'd6;
    #1 chk("oor_ready", 64'(launch_ready), 64'h0);
    launch(6, 32'h700, 32'h7);
    chk("oor_launch", 64'(ctx_valid), 64'h1);

    launch(1, 32'h200, 32'h3);
    launch(2, 32'h300, 32'h5);
    launch(3, 32'h3F0, 32'h9);
    chk("four_valid", 64'(ctx_valid), 64'hF);

    evt(0, 2'd2);
    evt(1, 2'd2);
    evt(2, 2'd2);
    chk("bar3_no_rel", 64'(bar_release), 64'h0);
    chk("bar3_st", 64'(ctx_status[11:0]), 64'({S_READY, S_BLOCKED, S_BLOCKED, S_BLOCKED}));
    evt(3, 2'd2);
    chk("bar4_blocked", 64'(ctx_status[11:0]), 64'({4{S_BLOCKED}}));
    tick();
    chk("rel_st", 64'(ctx_status[11:0]), 64'({4{S_READY}}));
    chk("rel_pulse", 64'(bar_release), 64'h1);
    tick();
    chk("rel_pulse_end", 64'(bar_release), 64'h0);

    evt(3, 2'd3);
    chk("exit_st3", 64'(st(3)), 64'(S_DONE));
    chk("exit_valid3", 64'(ctx_valid[3]), 64'h1);
    launch_warp_id = 3;
    #1 chk("exit_ready3", 64'(launch_ready), 64'h1);
    evt(0, 2'd2);
    evt(1, 2'd2);
    evt(2, 2'd2);
    chk("bar_wo3_blk", 64'(ctx_status[11:0]), 64'({S_DONE, S_BLOCKED, S_BLOCKED, S_BLOCKED}));
    tick();
    chk("rel_wo3_st", 64'(ctx_status[11:0]), 64'({S_DONE, S_READY, S_READY, S_READY}));
    chk("rel_wo3_pulse", 64'(bar_release), 64'h1);

    evt(2, 2'd0);
    chk("wait_w2", 64'(st(2)), 64'(S_WAITING));
    evt(2, 2'd1);
    chk("wake_w2", 64'(st(2)), 64'(S_READY));
    evt(1, 2'd1);
    chk("wake_ready_w1", 64'(st(1)), 64'(S_READY));

    evt(2, 2'd0);
    issue_ack = 1; issue_warp_id = 2;
    tick();
    issue_ack = 0;
    chk("issue_waiting_pc", 64'(pcv(2)), 64'h300);

    issue_ack = 1; issue_warp_id = 1;
    evt_valid = 1; evt_warp_id = 0; evt_op = 2'd0;
    pc_wr_valid = 1; pc_wr_warp_id = 2; pc_wr_pc = 32'h5000; pc_wr_mask = 32'h3;
    tick();
    idle_inputs();
    chk("multi_issue_w1", 64'(pcv(1)), 64'h204);
    chk("multi_wait_w0", 64'(st(0)), 64'(S_WAITING));
    chk("multi_pcwr_w2", 64'(pcv(2)), 64'h5000);

    for (int i = 0; i < 300; i++) tick();
`ifdef WARP_CTX_AGE_EN
    chk("age_sat_w1", 64'(agev(1)), 64'hFF);
`else
    chk("age_off", 64'(ctx_age), 64'h0);
`endif
    issue_ack = 1; issue_warp_id = 1;
    tick();
    issue_ack = 0;
    chk("age_issue_w1", 64'(agev(1)), 64'h0);
    chk("issue_w1_pc", 64'(pcv(1)), 64'h208);

    evt(1, 2'd2);
    chk("mid_bar_blk", 64'(st(1)), 64'(S_BLOCKED));
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_valid", 64'(ctx_valid), 64'h0);
    chk("midrst_status", 64'(ctx_status), 64'({NW{S_DONE}}));
    chk("midrst_bar", 64'(bar_release), 64'h0);
    tick();
    chk("midrst_bar2", 64'(bar_release), 64'h0);
    chk("midrst_pc1", 64'(pcv(1)), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
